// File: rtl/cont_pkg.sv
// Shared constants and sizing helper for the up/down counter family.
package cont_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Bits needed to hold the values 0..n-1; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(n)) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cont_presc_tick.sv
// Prescaler for cont_updown_mod: counts enabled cycles and raises tick every DIV-th one.
// Latency: tick is a combinational decode of the count; clr takes priority over en.
import cont_pkg::*;

module cont_presc_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW_RAW = clog2(DIV);
    localparam int PW     = (PW_RAW < 1) ? 1 : PW_RAW;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cont_updown_mod.sv
// Parametrised up/down counter with load, wrap/saturate, terminal-count pulse and limit flags.
// Optional prescaler enabled by defining CONT_PRESC_EN; otherwise every enabled cycle steps.
import cont_pkg::*;

module cont_updown_mod #(
    parameter int WIDTH     = 4,
    parameter int MAX_VAL   = 2**WIDTH - 1,
    parameter int SAT       = 0,
    parameter int PRESC_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ctrl,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sal,
    output logic             tc,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

    logic tick;

`ifdef CONT_PRESC_EN
    cont_presc_tick #(
        .DIV (PRESC_DIV)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .tick (tick)
    );
`else
    // An illegal divider (< 1) simply never steps.
    assign tick = (PRESC_DIV >= 1);
`endif

    assign at_max  = (sal == MAXV);
    assign at_zero = (sal == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sal <= '0;
            tc  <= 1'b0;
        end else if (load) begin
            sal <= (din > MAXV) ? MAXV : din;
            tc  <= 1'b0;
        end else if (en && tick) begin
            if (ctrl == DIR_UP) begin
                if (sal >= MAXV) begin
                    tc <= 1'b1;
                    if (SAT != MODE_SAT) sal <= '0;
                end else begin
                    sal <= sal + 1'b1;
                    tc  <= 1'b0;
                end
            end else begin
                if (sal == '0) begin
                    tc <= 1'b1;
                    if (SAT != MODE_SAT) sal <= MAXV;
                end else begin
                    sal <= sal - 1'b1;
                    tc  <= 1'b0;
                end
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule

// File: doc/cont_updown_mod.md
Name: cont_updown_mod

Overview:
- Parametrised up/down counter; next generation of the team's 4-bit up/down counter.
- Adds: configurable width and modulus, wrap or saturate mode, count enable, synchronous parallel load, terminal-count pulse and limit flags.
- Used as a general event/timebase counter (e.g. decade digit counters, cascaded timers) in FPGA designs.

Parameters:
- WIDTH, 4, counter width in bits (>=2).
- MAX_VAL, 2**WIDTH-1, top of count range; range is 0..MAX_VAL; must be < 2**WIDTH.
- SAT, 0, 0 = wrap-around at limits; 1 = saturate at limits.
- PRESC_DIV, 1, prescaler ratio (>=1); used only when CONT_PRESC_EN is defined.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  count enable; a step is requested only when high.
- ctrl  in  1  direction: 0 = up (+1), 1 = down (-1).
- load  in  1  synchronous parallel load strobe.
- din  in  WIDTH  load value.
- sal  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered, one cycle per boundary event.
- at_max  out  1  high while sal == MAX_VAL; combinational decode of sal.
- at_zero  out  1  high while sal == 0; combinational decode of sal.

Behaviour:
- Reset: rst low forces sal=0, tc=0 and prescaler state=0 immediately, independent of clk. This applies mid-operation too. First update occurs on the first rising edge after rst goes high.
- Priority at each rising edge: load > step > hold.
- Load: sal <= min(din, MAX_VAL); tc <= 0; prescaler count cleared. Load with en in the same cycle loads and does not step.
- Step: occurs when en=1, load=0 and the prescaler tick is 1. Without the macro, tick is always 1.
  - Up, sal < MAX_VAL: sal+1, tc <= 0.
  - Up, sal == MAX_VAL: SAT=0 gives sal <= 0, tc <= 1. SAT=1 holds sal, tc <= 1.
  - Down, sal > 0: sal-1, tc <= 0.
  - Down, sal == 0: SAT=0 gives sal <= MAX_VAL, tc <= 1. SAT=1 holds sal, tc <= 1.
- No step: sal holds, tc <= 0. tc is never high for two cycles unless consecutive boundary steps occur; in SAT mode a held boundary keeps tc high.
- A ctrl change is effective on the same edge; there is no pipeline delay. Latency from en to sal change is 1 cycle.
- All arithmetic is WIDTH bits. The compare against MAX_VAL prevents any illegal value from appearing on sal.
- at_max and at_zero are never both high, since MAX_VAL > 0.

Optional Feature:
- Macro: CONT_PRESC_EN.
- Defined: an internal prescaler counter, ceil(log2(PRESC_DIV)) bits wide, increments on cycles with en=1 and load=0.
  - tick is high on the cycle the prescaler count equals PRESC_DIV-1; the count then returns to 0.
  - sal steps only on tick cycles. en=0 freezes the prescaler.
  - PRESC_DIV=1 behaves identically to the macro being undefined.
- Undefined: no prescaler logic; tick is tied to 1 and PRESC_DIV is ignored.

Decomposition:
- Shared package cont_pkg holds:
  - direction constants DIR_UP=0 and DIR_DOWN=1;
  - mode constants MODE_WRAP=0 and MODE_SAT=1;
  - a clog2 helper function for prescaler sizing.
- One natural sub-module: cont_presc_tick. It holds the prescaler counter and tick output (clk, rst, en, clr, tick) and is instantiated only under CONT_PRESC_EN.

Test Plan:
1. WIDTH=4, MAX_VAL=9. Count to sal=5, then drive rst low between clock edges -> sal=0 and tc=0 without waiting for a clock edge; after release, en=1 up gives sal=1 on the next edge.
2. WIDTH=4, MAX_VAL=9, SAT=0, ctrl=0, en=1 for 10 cycles from 0 -> sal 1..9 then 0; tc=1 only in the cycle sal shows 0; at_max high while sal=9.
3. Same config, ctrl=1 from sal=0 for 2 cycles -> sal 9, 8; tc=1 only with sal=9; at_zero low after the first step.
4. SAT=1, MAX_VAL=9, load din=8, then up for 3 cycles -> sal 9, 9, 9; tc=0, 1, 1; down once -> sal=8, tc=0.
5. MAX_VAL=9: load din=12 -> sal=9. load=1 with en=1, ctrl=0, din=3 -> sal=3 (no increment), tc=0.
6. CONT_PRESC_EN defined, PRESC_DIV=3, en held for 9 cycles from 0 -> sal steps on cycles 3, 6 and 9, ending at 3; en=0 for 2 cycles, then en=1 -> next step occurs after 3 more enabled cycles.
